// File: rtl/x_stream_fetcher_if.sv
// Bundle of the fetcher's stream, TCDM read-port and output signals.
// master = the fetcher itself, slave = its surroundings (scheduler, memory, datapath).
interface x_stream_fetcher_if #(
    parameter int unsigned BW              = 128,
    parameter int unsigned DATA_SIZE       = 32,
    parameter int unsigned META_CHUNK_SIZE = 32,
    parameter int unsigned ADDR_W          = 32
);
    logic [ADDR_W-1:0]          meta_end_addr_i;
    logic                       addr_valid_i;
    logic                       addr_ready_o;
    logic [ADDR_W-1:0]          addr_data_i;
    logic                       num_valid_i;
    logic                       num_ready_o;
    logic [7:0]                 num_data_i;
    logic                       mem_req_o;
    logic                       mem_gnt_i;
    logic [ADDR_W-1:0]          mem_add_o;
    logic                       mem_r_valid_i;
    logic [BW-1:0]              mem_r_data_i;
    logic [META_CHUNK_SIZE-1:0] meta_chunk_o;
    logic                       meta_loaded_o;
    logic                       x_valid_o;
    logic                       x_ready_i;
    logic [BW-1:0]              x_data_o;
    logic [7:0]                 x_num_o;
    logic                       busy_o;

    modport master (
        input  meta_end_addr_i, addr_valid_i, addr_data_i, num_valid_i, num_data_i,
               mem_gnt_i, mem_r_valid_i, mem_r_data_i, x_ready_i,
        output addr_ready_o, num_ready_o, mem_req_o, mem_add_o, meta_chunk_o,
               meta_loaded_o, x_valid_o, x_data_o, x_num_o, busy_o
    );
    modport slave (
        output meta_end_addr_i, addr_valid_i, addr_data_i, num_valid_i, num_data_i,
               mem_gnt_i, mem_r_valid_i, mem_r_data_i, x_ready_i,
        input  addr_ready_o, num_ready_o, mem_req_o, mem_add_o, meta_chunk_o,
               meta_loaded_o, x_valid_o, x_data_o, x_num_o, busy_o
    );
endinterface

// File: rtl/x_stream_fetcher.sv
// X stream fetcher: pops address/count streams, reads BW-wide TCDM lines (two for unaligned runs),
// routes metadata chunks back to the scheduler and packed elements to the datapath.
// Optional counters: define X_STREAM_FETCHER_STATS_EN.
module x_stream_fetcher_lane #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned IDX       = 0
) (
    input  logic [7:0]           n_i,
    input  logic [DATA_SIZE-1:0] d_i,
    output logic [DATA_SIZE-1:0] d_o
);
    assign d_o = (8'(IDX) < n_i) ? d_i : '0;
endmodule

module x_stream_fetcher #(
    parameter int unsigned BW              = 128,
    parameter int unsigned DATA_SIZE       = 32,
    parameter int unsigned META_CHUNK_SIZE = 32,
    parameter int unsigned ADDR_W          = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    x_stream_fetcher_if.master  bus
`ifdef X_STREAM_FETCHER_STATS_EN
    ,
    output logic [31:0]         stat_reqs_o,
    output logic [31:0]         stat_splits_o,
    output logic [31:0]         stat_stall_o
`endif
);
    localparam int unsigned BB    = BW / 8;
    localparam int unsigned EPW   = BW / DATA_SIZE;
    localparam int unsigned LB    = $clog2(BB);
    localparam int unsigned EB    = $clog2(DATA_SIZE / 8);
    localparam int unsigned CB    = $clog2(META_CHUNK_SIZE / 8);
    localparam int unsigned NCH   = BW / META_CHUNK_SIZE;
    localparam int unsigned OFF_W = LB - EB;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ0  = 3'd1;
    localparam logic [2:0] S_WAIT0 = 3'd2;
    localparam logic [2:0] S_REQ1  = 3'd3;
    localparam logic [2:0] S_WAIT1 = 3'd4;
    localparam logic [2:0] S_OUT   = 3'd5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              meta;
        logic [7:0]        n;
        logic [OFF_W-1:0]  off;
    } txn_t;

    logic [2:0]                 state_q;
    txn_t                       txn_q;
    logic [BW-1:0]              first_q;
    logic [BW-1:0]              x_data_q;
    logic [META_CHUNK_SIZE-1:0] meta_q;
    logic                       meta_ld_q;

    logic is_meta, idle, accept, need_split;
    logic [7:0] n_in;
    logic [ADDR_W-1:0] line_addr;

    assign idle    = (state_q == S_IDLE);
    assign is_meta = (bus.addr_data_i < bus.meta_end_addr_i);
    // Data addresses only pop together with their count, so the two streams never drift apart.
    assign bus.addr_ready_o = idle && (is_meta || bus.num_valid_i);
    assign bus.num_ready_o  = idle && bus.addr_valid_i && !is_meta;
    assign accept           = bus.addr_valid_i && bus.addr_ready_o;
    assign n_in = (bus.num_data_i > 8'(EPW)) ? 8'(EPW) : bus.num_data_i;

    assign line_addr  = {txn_q.addr[ADDR_W-1:LB], LB'(0)};
    assign need_split = (9'(txn_q.off) + 9'(txn_q.n)) > 9'(EPW);

    assign bus.mem_req_o = (state_q == S_REQ0) || (state_q == S_REQ1);
    assign bus.mem_add_o = (state_q == S_REQ0) ? line_addr :
                           (state_q == S_REQ1) ? line_addr + ADDR_W'(BB) : '0;

    // Element alignment: the run starts at lane 'off' of the first line, possibly spilling into the next.
    logic [2*BW-1:0] cat;
    logic [BW-1:0]   sh;
    logic [EPW-1:0][DATA_SIZE-1:0] sh_lanes, x_lanes;
    assign cat      = (state_q == S_WAIT1) ? {bus.mem_r_data_i, first_q} : {BW'(0), bus.mem_r_data_i};
    assign sh       = BW'(cat >> (int'(txn_q.off) * DATA_SIZE));
    assign sh_lanes = sh;

    for (genvar g = 0; g < EPW; g++) begin : g_lane
        x_stream_fetcher_lane #(.DATA_SIZE(DATA_SIZE), .IDX(g)) u_lane (
            .n_i (txn_q.n),
            .d_i (sh_lanes[g]),
            .d_o (x_lanes[g])
        );
    end

    logic [NCH-1:0][META_CHUNK_SIZE-1:0] chunks;
    assign chunks = bus.mem_r_data_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            txn_q     <= '0;
            first_q   <= '0;
            x_data_q  <= '0;
            meta_q    <= '0;
            meta_ld_q <= 1'b0;
        end else if (clear_i) begin
            state_q   <= S_IDLE;
            txn_q     <= '0;
            first_q   <= '0;
            x_data_q  <= '0;
            meta_q    <= '0;
            meta_ld_q <= 1'b0;
        end else begin
            meta_ld_q <= 1'b0;
            case (state_q)
                S_IDLE: if (accept) begin
                    txn_q.addr <= bus.addr_data_i;
                    txn_q.meta <= is_meta;
                    txn_q.n    <= n_in;
                    txn_q.off  <= bus.addr_data_i[LB-1:EB];
                    if (is_meta || bus.num_data_i != 8'd0) state_q <= S_REQ0;
                end
                S_REQ0: if (bus.mem_gnt_i) state_q <= S_WAIT0;
                S_WAIT0: if (bus.mem_r_valid_i) begin
                    first_q <= bus.mem_r_data_i;
                    if (txn_q.meta) begin
                        meta_q    <= chunks[txn_q.addr[LB-1:CB]];
                        meta_ld_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else if (need_split) begin
                        state_q <= S_REQ1;
                    end else begin
                        x_data_q <= x_lanes;
                        state_q  <= S_OUT;
                    end
                end
                S_REQ1: if (bus.mem_gnt_i) state_q <= S_WAIT1;
                S_WAIT1: if (bus.mem_r_valid_i) begin
                    x_data_q <= x_lanes;
                    state_q  <= S_OUT;
                end
                S_OUT: if (bus.x_ready_i) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.x_valid_o     = (state_q == S_OUT);
    assign bus.x_data_o      = (state_q == S_OUT) ? x_data_q : '0;
    assign bus.x_num_o       = (state_q == S_OUT) ? txn_q.n : 8'd0;
    assign bus.meta_chunk_o  = meta_q;
    assign bus.meta_loaded_o = meta_ld_q;
    assign bus.busy_o        = !idle;

`ifdef X_STREAM_FETCHER_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_reqs_o   <= '0;
            stat_splits_o <= '0;
            stat_stall_o  <= '0;
        end else if (clear_i) begin
            stat_reqs_o   <= '0;
            stat_splits_o <= '0;
            stat_stall_o  <= '0;
        end else begin
            if (bus.mem_req_o && bus.mem_gnt_i && stat_reqs_o != '1)
                stat_reqs_o <= stat_reqs_o + 32'd1;
            if (state_q == S_WAIT0 && bus.mem_r_valid_i && !txn_q.meta && need_split
                && stat_splits_o != '1)
                stat_splits_o <= stat_splits_o + 32'd1;
            if (state_q == S_OUT && !bus.x_ready_i && stat_stall_o != '1)
                stat_stall_o <= stat_stall_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_x_stream_fetcher.sv
// Directed bench for x_stream_fetcher: vector table of single transactions plus
// hand sequences for backpressure, clear and reset-during-read.
module tb_x_stream_fetcher;
    localparam int BW = 128, DS = 32, MCS = 32, AW = 32;

    logic clk_i = 1'b0, rst_ni = 1'b0, clear_i = 1'b0;
    always #5 clk_i = ~clk_i;

    x_stream_fetcher_if #(.BW(BW), .DATA_SIZE(DS), .META_CHUNK_SIZE(MCS), .ADDR_W(AW)) bif ();
`ifdef X_STREAM_FETCHER_STATS_EN
    logic [31:0] stat_reqs, stat_splits, stat_stall;
`endif

    x_stream_fetcher #(.BW(BW), .DATA_SIZE(DS), .META_CHUNK_SIZE(MCS), .ADDR_W(AW)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .bus     (bif)
`ifdef X_STREAM_FETCHER_STATS_EN
        ,
        .stat_reqs_o   (stat_reqs),
        .stat_splits_o (stat_splits),
        .stat_stall_o  (stat_stall)
`endif
    );

    int nvec = 0, nerr = 0;
    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // memory image: word i holds 0x1000_0000|i, except word 1 = 0xDEADBEEF
    function automatic logic [31:0] w(input logic [31:0] i);
        return (i == 32'd1) ? 32'hDEADBEEF : (32'h1000_0000 | i);
    endfunction
    function automatic logic [BW-1:0] line(input logic [31:0] a);
        logic [31:0] i;
        i = {2'b00, a[31:2]};
        return {w(i + 3), w(i + 2), w(i + 1), w(i)};
    endfunction

    // monitor / memory responder state (written only by the process below)
    int cyc = 0;
    int addr_pops = 0, num_pops = 0, meta_pulses = 0, req_cycles = 0, x_count = 0;
    int add_unstable = 0, x_unstable = 0, ready_busy = 0, gnt_total = 0;
    int pop_cyc = 0, xv_cyc = 0, hs_cyc = 0;
    logic [BW-1:0] last_xd;
    logic [7:0] last_xn;
    logic [31:0] grants[$];
    // controls written only by the main process
    bit auto_mem = 1'b1;
    int gnt_delay = 0;
    logic man_gnt = 1'b0, man_rv = 1'b0;

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    initial begin
        bit prev_req, prev_gnt, prev_xv, resp_pend;
        logic [31:0] prev_add, resp_add;
        logic [BW-1:0] prev_xd;
        logic [7:0] prev_xn;
        int wait_cnt;
        prev_req = 0; prev_gnt = 0; prev_xv = 0; resp_pend = 0; wait_cnt = 0;
        prev_add = '0; resp_add = '0; prev_xd = '0; prev_xn = '0;
        last_xd = '0; last_xn = '0;
        bif.mem_gnt_i = 1'b0; bif.mem_r_valid_i = 1'b0; bif.mem_r_data_i = '0;
        forever begin
            @(negedge clk_i);
            if (bif.addr_valid_i && bif.addr_ready_o) begin addr_pops++; pop_cyc = cyc; end
            if (bif.num_valid_i && bif.num_ready_o) num_pops++;
            if (bif.meta_loaded_o) meta_pulses++;
            if (bif.busy_o && bif.addr_ready_o) ready_busy++;
            if (bif.mem_req_o) begin
                req_cycles++;
                if (prev_req && !prev_gnt && bif.mem_add_o !== prev_add) add_unstable++;
            end
            if (bif.x_valid_o) begin
                if (!prev_xv) xv_cyc = cyc;
                else if (bif.x_data_o !== prev_xd || bif.x_num_o !== prev_xn) x_unstable++;
                if (bif.x_ready_i) begin
                    x_count++; hs_cyc = cyc; last_xd = bif.x_data_o; last_xn = bif.x_num_o;
                end
            end
            prev_req = bif.mem_req_o; prev_add = bif.mem_add_o; prev_xv = bif.x_valid_o;
            prev_xd = bif.x_data_o; prev_xn = bif.x_num_o;
            if (auto_mem) begin
                bif.mem_r_valid_i = resp_pend;
                bif.mem_r_data_i  = resp_pend ? line(resp_add) : '0;
                resp_pend = 0;
                if (bif.mem_req_o && wait_cnt >= gnt_delay) begin
                    bif.mem_gnt_i = 1'b1; resp_pend = 1; resp_add = bif.mem_add_o;
                    grants.push_back(bif.mem_add_o); gnt_total++; wait_cnt = 0;
                end else begin
                    bif.mem_gnt_i = 1'b0;
                    wait_cnt = bif.mem_req_o ? wait_cnt + 1 : 0;
                end
            end else begin
                resp_pend = 0; wait_cnt = 0;
                bif.mem_gnt_i     = man_gnt;
                bif.mem_r_valid_i = man_rv;
                bif.mem_r_data_i  = man_rv ? line(32'h0000_0100) : '0;
            end
            prev_gnt = bif.mem_gnt_i;
        end
    end

    task automatic wait_pop(input int base);
        int k;
        k = 0;
        while (addr_pops == base && k < 50) begin @(posedge clk_i); #1; k++; end
        chk("pop_timeout", 1'(addr_pops == base), 1'b0);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (bif.busy_o && k < 100) begin @(posedge clk_i); #1; k++; end
        chk("idle_timeout", bif.busy_o, 1'b0);
        @(negedge clk_i); #1;
    endtask

    typedef struct {
        logic [31:0]   addr;
        logic [7:0]    n;
        int            nrd;
        logic [31:0]   a0, a1;
        bit            xv;
        logic [7:0]    xn;
        logic [BW-1:0] xd;
        bit            meta;
        logic [31:0]   mchunk;
    } vec_t;
    vec_t vt[11];

    initial begin
        int exp_splits, p0, n0, m0, x0, g0, r0, k;
        exp_splits = 0;
        vt[0]  = '{32'h0000_0004, 8'd2, 1, 32'h0, 32'h0, 0, 8'd0, '0, 1, 32'hDEADBEEF};
        vt[1]  = '{32'h0000_000C, 8'd2, 1, 32'h0, 32'h0, 0, 8'd0, '0, 1, 32'h1000_0003};
        vt[2]  = '{32'h0000_00FC, 8'd2, 1, 32'hF0, 32'h0, 0, 8'd0, '0, 1, 32'h1000_003F};
        vt[3]  = '{32'h0000_0100, 8'd3, 1, 32'h100, 32'h0, 1, 8'd3,
                   {32'h0, 32'h1000_0042, 32'h1000_0041, 32'h1000_0040}, 0, 32'h0};
        vt[4]  = '{32'h0000_0108, 8'd4, 2, 32'h100, 32'h110, 1, 8'd4,
                   {32'h1000_0045, 32'h1000_0044, 32'h1000_0043, 32'h1000_0042}, 0, 32'h0};
        vt[5]  = '{32'h0000_0120, 8'd0, 0, 32'h0, 32'h0, 0, 8'd0, '0, 0, 32'h0};
        vt[6]  = '{32'h0000_0130, 8'd9, 1, 32'h130, 32'h0, 1, 8'd4,
                   {32'h1000_004F, 32'h1000_004E, 32'h1000_004D, 32'h1000_004C}, 0, 32'h0};
        vt[7]  = '{32'h0000_0104, 8'd3, 1, 32'h100, 32'h0, 1, 8'd3,
                   {32'h0, 32'h1000_0043, 32'h1000_0042, 32'h1000_0041}, 0, 32'h0};
        vt[8]  = '{32'h0000_010C, 8'd1, 1, 32'h100, 32'h0, 1, 8'd1,
                   {32'h0, 32'h0, 32'h0, 32'h1000_0043}, 0, 32'h0};
        vt[9]  = '{32'h0000_010C, 8'd2, 2, 32'h100, 32'h110, 1, 8'd2,
                   {32'h0, 32'h0, 32'h1000_0044, 32'h1000_0043}, 0, 32'h0};
        vt[10] = '{32'hFFFF_FFF8, 8'd4, 2, 32'hFFFF_FFF0, 32'h0, 1, 8'd4,
                   {32'hDEADBEEF, 32'h1000_0000, 32'h3FFF_FFFF, 32'h3FFF_FFFE}, 0, 32'h0};

        bif.meta_end_addr_i = 32'h100;
        bif.addr_valid_i = 1'b0; bif.addr_data_i = '0;
        bif.num_valid_i = 1'b0; bif.num_data_i = '0; bif.x_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_busy", bif.busy_o, 1'b0);
        chk("rst_mem_req", bif.mem_req_o, 1'b0);
        chk("rst_mem_add", bif.mem_add_o, '0);
        chk("rst_x_valid", bif.x_valid_o, 1'b0);
        chk("rst_x_data", bif.x_data_o, '0);
        chk("rst_meta_chunk", bif.meta_chunk_o, '0);
        chk("rst_meta_loaded", bif.meta_loaded_o, 1'b0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("idle_num_ready", bif.num_ready_o, 1'b0);

        for (int i = 0; i < 11; i++) begin
            p0 = addr_pops; n0 = num_pops; m0 = meta_pulses; x0 = x_count; g0 = grants.size();
            @(posedge clk_i); #1;
            bif.addr_valid_i = 1'b1; bif.addr_data_i = vt[i].addr;
            bif.num_valid_i = 1'b1; bif.num_data_i = vt[i].n;
            wait_pop(p0);
            bif.addr_valid_i = 1'b0; bif.num_valid_i = 1'b0;
            wait_idle();
            if (vt[i].nrd == 2) exp_splits++;
            chk($sformatf("v%0d_nreads", i), 32'(grants.size() - g0), 32'(vt[i].nrd));
            if (grants.size() > g0) chk($sformatf("v%0d_addr0", i), grants[g0], vt[i].a0);
            if (grants.size() > g0 + 1) chk($sformatf("v%0d_addr1", i), grants[g0 + 1], vt[i].a1);
            chk($sformatf("v%0d_num_pop", i), 32'(num_pops - n0), vt[i].meta ? 32'd0 : 32'd1);
            chk($sformatf("v%0d_meta_pulse", i), 32'(meta_pulses - m0), vt[i].meta ? 32'd1 : 32'd0);
            chk($sformatf("v%0d_x_count", i), 32'(x_count - x0), 32'(vt[i].xv));
            if (vt[i].meta) chk($sformatf("v%0d_meta_chunk", i), bif.meta_chunk_o, vt[i].mchunk);
            if (vt[i].xv) begin
                chk($sformatf("v%0d_x_data", i), last_xd, vt[i].xd);
                chk($sformatf("v%0d_x_num", i), last_xn, vt[i].xn);
                if (vt[i].nrd == 1) chk($sformatf("v%0d_latency", i), 32'(xv_cyc - pop_cyc), 32'd3);
            end
        end

        // backpressure: 5-cycle grant delay per read, 4 stall cycles, meta request waiting behind
        gnt_delay = 5; bif.x_ready_i = 1'b0;
        p0 = addr_pops; r0 = req_cycles;
        @(posedge clk_i); #1;
        bif.addr_valid_i = 1'b1; bif.addr_data_i = 32'h108; bif.num_valid_i = 1'b1; bif.num_data_i = 8'd4;
        wait_pop(p0);
        bif.addr_data_i = 32'h4; bif.num_valid_i = 1'b0;
        k = 0;
        while (!bif.x_valid_o && k < 100) begin @(posedge clk_i); #1; k++; end
        chk("bp_xvalid_timeout", bif.x_valid_o, 1'b1);
        chk("bp_req_cycles", 32'(req_cycles - r0), 32'd12);
        p0 = addr_pops;
        repeat (4) @(posedge clk_i);
        #1;
        bif.x_ready_i = 1'b1;
        wait_pop(p0);
        bif.addr_valid_i = 1'b0;
        chk("bp_pop_after_out", 32'(pop_cyc - hs_cyc), 32'd1);
        wait_idle();
        gnt_delay = 0;
        chk("bp_x_data", last_xd, {32'h1000_0045, 32'h1000_0044, 32'h1000_0043, 32'h1000_0042});
        chk("bp_meta_chunk", bif.meta_chunk_o, 32'hDEADBEEF);
        chk("add_stable", 32'(add_unstable), 32'd0);
        chk("x_stable", 32'(x_unstable), 32'd0);
        chk("ready_while_busy", 32'(ready_busy), 32'd0);
`ifdef X_STREAM_FETCHER_STATS_EN
        chk("stat_stall", stat_stall, 32'd4);
        chk("stat_splits", stat_splits, 32'(exp_splits + 1));
        chk("stat_reqs", stat_reqs, 32'(gnt_total));
`endif

        // clear while holding output
        bif.x_ready_i = 1'b0; p0 = addr_pops; x0 = x_count;
        @(posedge clk_i); #1;
        bif.addr_valid_i = 1'b1; bif.addr_data_i = 32'h100; bif.num_valid_i = 1'b1; bif.num_data_i = 8'd1;
        wait_pop(p0);
        bif.addr_valid_i = 1'b0; bif.num_valid_i = 1'b0;
        k = 0;
        while (!bif.x_valid_o && k < 50) begin @(posedge clk_i); #1; k++; end
        chk("clr_xvalid_timeout", bif.x_valid_o, 1'b1);
        clear_i = 1'b1;
        @(posedge clk_i); #1;
        clear_i = 1'b0;
        chk("clr_x_valid", bif.x_valid_o, 1'b0);
        chk("clr_busy", bif.busy_o, 1'b0);
        chk("clr_meta_chunk", bif.meta_chunk_o, '0);
`ifdef X_STREAM_FETCHER_STATS_EN
        chk("clr_stat_reqs", stat_reqs, '0);
`endif
        bif.x_ready_i = 1'b1;

        // reset during WAIT0, response arrives after release
        auto_mem = 1'b0; p0 = addr_pops;
        @(posedge clk_i); #1;
        bif.addr_valid_i = 1'b1; bif.addr_data_i = 32'h100; bif.num_valid_i = 1'b1; bif.num_data_i = 8'd3;
        wait_pop(p0);
        bif.addr_valid_i = 1'b0; bif.num_valid_i = 1'b0;
        chk("rw_mem_req", bif.mem_req_o, 1'b1);
        man_gnt = 1'b1;
        @(posedge clk_i); #1;
        man_gnt = 1'b0;
        chk("rw_in_wait", {bif.busy_o, bif.mem_req_o}, 2'b10);
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1; man_rv = 1'b1; x0 = x_count;
        @(posedge clk_i); #1;
        man_rv = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rw_busy", bif.busy_o, 1'b0);
        chk("rw_x_valid", bif.x_valid_o, 1'b0);
        chk("rw_x_count", 32'(x_count - x0), 32'd0);
        chk("rw_x_data", bif.x_data_o, '0);
        chk("rw_meta_loaded", bif.meta_loaded_o, 1'b0);
        auto_mem = 1'b1; p0 = addr_pops;
        @(posedge clk_i); #1;
        bif.addr_valid_i = 1'b1; bif.addr_data_i = 32'h104; bif.num_valid_i = 1'b1; bif.num_data_i = 8'd3;
        wait_pop(p0);
        bif.addr_valid_i = 1'b0; bif.num_valid_i = 1'b0;
        wait_idle();
        chk("rw_next_x_count", 32'(x_count - x0), 32'd1);
        chk("rw_next_x_data", last_xd, {32'h0, 32'h1000_0043, 32'h1000_0042, 32'h1000_0041});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
